// File: rtl/gcd_pkg.sv
// Shared definitions for the subtract-and-compare GCD engine.
package gcd_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_ctrl_fsm.sv
// Control FSM for the GCD engine: sequencing, handshakes and datapath strobes.
module gcd_ctrl_fsm
    import gcd_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic in_valid,
    input  logic out_ready,
    input  logic x_eq_y,
    input  logic x_gt_y,
    input  logic any_zero,
    output logic ld_xy,
    output logic sub_x,
    output logic sub_y,
    output logic ld_res,
    output logic in_ready,
    output logic out_valid,
    output logic busy
);

    gcd_state_e state_q, state_d;
    logic       finish;

    assign finish = any_zero | x_eq_y;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (in_valid) state_d = StCalc;
            StCalc: if (finish) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;  // unused encoding recovers
        endcase
    end

    // Status outputs decode registered state only; strobes are internal.
    always_comb begin
        ld_xy     = 1'b0;
        sub_x     = 1'b0;
        sub_y     = 1'b0;
        ld_res    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                ld_xy    = in_valid;
            end
            StCalc: begin
                busy   = 1'b1;
                ld_res = finish;
                sub_x  = ~finish & x_gt_y;
                sub_y  = ~finish & ~x_gt_y;
            end
            StDone: begin
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD unit: one subtraction per clock, valid/ready on both sides.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic             busy,
    output logic [WIDTH-1:0] iter_cnt
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] iter_q, iter_d;
    logic [WIDTH-1:0] iter_inc;
    logic             x_eq_y, x_gt_y, any_zero;
    logic             ld_xy, sub_x, sub_y, ld_res;

    assign x_eq_y   = (x_q == y_q);
    assign x_gt_y   = (x_q > y_q);
    assign any_zero = (x_q == '0) | (y_q == '0);
    assign iter_inc = (iter_q == '1) ? iter_q : iter_q + 1'b1;

    gcd_ctrl_fsm u_ctrl (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .x_eq_y    (x_eq_y),
        .x_gt_y    (x_gt_y),
        .any_zero  (any_zero),
        .ld_xy     (ld_xy),
        .sub_x     (sub_x),
        .sub_y     (sub_y),
        .ld_res    (ld_res),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .busy      (busy)
    );

    // Subtraction is always larger-minus-smaller, so it can never underflow.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        res_d  = res_q;
        iter_d = iter_q;
        if (ld_xy) begin
            x_d    = xin;
            y_d    = yin;
            iter_d = '0;
        end else if (sub_x) begin
            x_d    = x_q - y_q;
            iter_d = iter_inc;
        end else if (sub_y) begin
            y_d    = y_q - x_q;
            iter_d = iter_inc;
        end
        if (ld_res) begin
            res_d = any_zero ? (x_q | y_q) : x_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            x_q    <= '0;
            y_q    <= '0;
            res_q  <= '0;
            iter_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            res_q  <= res_d;
            iter_q <= iter_d;
        end
    end

    assign gcd_out  = res_q;
    assign iter_cnt = iter_q;

endmodule
